inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 80 ++++++++
 tb/tb_inst_fetch_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Four-entry instruction/PC FIFO between fetch and decode.
// Flush redirects discard everything queued; the head is presented combinationally.
module inst_fetch_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst_in,
    input  logic [15:0] pc_in,
    input  logic        push_in,
    input  logic        pop_in,
    input  logic        flush_in,
    output logic        push_rdy_out,
    output logic [15:0] inst_out,
    output logic [15:0] pc_out,
    output logic [3:0]  opco_out,
    output logic [1:0]  jmp_off_out,
    output logic        vld_out,
    output logic [2:0]  count_out
);

    logic [15:0] inst_mem [4];
    logic [15:0] pc_mem   [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        push_acc;
    logic        pop_acc;

    assign push_rdy_out = (count != 3'd4);
    assign vld_out      = (count != 3'd0);
    assign count_out    = count;

    // Acceptance looks only at registered occupancy, so a pop never frees a slot for a same-cycle push.
    assign push_acc = push_in && push_rdy_out && !flush_in;
    assign pop_acc  = pop_in && vld_out && !flush_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else if (flush_in) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push_acc, pop_acc})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared; pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            inst_mem[wr_ptr] <= inst_in;
            pc_mem[wr_ptr]   <= pc_in;
        end
    end

    always_comb begin
        inst_out = 16'h0000;
        pc_out   = 16'h0000;
        if (vld_out) begin
            inst_out = inst_mem[rd_ptr];
            pc_out   = pc_mem[rd_ptr];
        end
    end

    assign opco_out    = inst_out[15:12];
    assign jmp_off_out = inst_out[11:10];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a queue-based scoreboard of expected entries.
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic [15:0] inst_in;
    logic [15:0] pc_in;
    logic        push_in;
    logic        pop_in;
    logic        flush_in;
    logic        push_rdy_out;
    logic [15:0] inst_out;
    logic [15:0] pc_out;
    logic [3:0]  opco_out;
    logic [1:0]  jmp_off_out;
    logic        vld_out;
    logic [2:0]  count_out;

    logic [31:0] model_q [$];
    int checks;
    int failures;

    inst_fetch_queue dut (
        .clk          (clk),
        .rst          (rst),
        .inst_in      (inst_in),
        .pc_in        (pc_in),
        .push_in      (push_in),
        .pop_in       (pop_in),
        .flush_in     (flush_in),
        .push_rdy_out (push_rdy_out),
        .inst_out     (inst_out),
        .pc_out       (pc_out),
        .opco_out     (opco_out),
        .jmp_off_out  (jmp_off_out),
        .vld_out      (vld_out),
        .count_out    (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compares every output against the scoreboard's idea of the queue.
    task automatic check_output(input string tag);
        logic [15:0] exp_inst;
        logic [15:0] exp_pc;
        exp_inst = 16'h0000;
        exp_pc   = 16'h0000;
        if (model_q.size() > 0) begin
            exp_inst = model_q[0][31:16];
            exp_pc   = model_q[0][15:0];
        end
        check({tag, ".count"}, 32'(count_out), 32'(model_q.size()));
        check({tag, ".vld"}, 32'(vld_out), 32'(model_q.size() != 0));
        check({tag, ".rdy"}, 32'(push_rdy_out), 32'(model_q.size() != 4));
        check({tag, ".inst"}, 32'(inst_out), 32'(exp_inst));
        check({tag, ".pc"}, 32'(pc_out), 32'(exp_pc));
        check({tag, ".opco"}, 32'(opco_out), 32'(exp_inst[15:12]));
        check({tag, ".jmp"}, 32'(jmp_off_out), 32'(exp_inst[11:10]));
    endtask

    // Drives one cycle; popped heads are compared before the edge against the scoreboard front.
    task automatic apply_stimulus(input string tag, input logic push, input logic [15:0] inst,
                                  input logic [15:0] pc, input logic pop, input logic flush);
        logic push_ok;
        logic pop_ok;
        @(negedge clk);
        push_in  = push;
        inst_in  = inst;
        pc_in    = pc;
        pop_in   = pop;
        flush_in = flush;
        #1;
        push_ok = push && (model_q.size() < 4) && !flush;
        pop_ok  = pop && (model_q.size() > 0) && !flush;
        if (pop_ok) begin
            check({tag, ".pop_inst"}, 32'(inst_out), 32'(model_q[0][31:16]));
            check({tag, ".pop_pc"}, 32'(pc_out), 32'(model_q[0][15:0]));
            void'(model_q.pop_front());
        end
        if (flush) begin
            model_q.delete();
        end
        if (push_ok) begin
            model_q.push_back({inst, pc});
        end
        @(posedge clk);
        #1;
        push_in  = 1'b0;
        pop_in   = 1'b0;
        flush_in = 1'b0;
        check_output(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        inst_in  = 16'h0000;
        pc_in    = 16'h0000;
        push_in  = 1'b0;
        pop_in   = 1'b0;
        flush_in = 1'b0;

        #3;
        check_output("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill to four entries.
        apply_stimulus("fill0", 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0);
        apply_stimulus("fill1", 1'b1, 16'h2345, 16'h0001, 1'b0, 1'b0);
        apply_stimulus("fill2", 1'b1, 16'h3456, 16'h0002, 1'b0, 1'b0);
        apply_stimulus("fill3", 1'b1, 16'h4567, 16'h0003, 1'b0, 1'b0);
        check("fill.opco_const", 32'(opco_out), 32'h1);

        // Push while full is dropped even with a simultaneous pop.
        apply_stimulus("full_drop", 1'b1, 16'h9999, 16'h0099, 1'b1, 1'b0);
        check("full_drop.head", 32'(inst_out), 32'h2345);
        apply_stimulus("drain1", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

        // Flush at count 2 beats push and pop.
        apply_stimulus("flush", 1'b1, 16'h7777, 16'h0077, 1'b1, 1'b1);

        // Empty pop alone, then pop+push while empty.
        apply_stimulus("empty_pop", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        apply_stimulus("empty_pp", 1'b1, 16'hABCD, 16'h0040, 1'b1, 1'b0);
        check("empty_pp.head", 32'(inst_out), 32'hABCD);
        apply_stimulus("empty_drain", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

        // Streaming across pointer wrap-around with occupancy held at one.
        apply_stimulus("wrap0", 1'b1, 16'h5000, 16'h0100, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            apply_stimulus($sformatf("wrap%0d", i), 1'b1, 16'(16'h5000 + i * 16'h0111),
                           16'(16'h0100 + i), 1'b1, 1'b0);
            check($sformatf("wrap%0d.steady", i), 32'(count_out), 32'd1);
        end
        apply_stimulus("wrap_drain", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

        // Async reset between edges at count 3.
        apply_stimulus("pre_rst0", 1'b1, 16'h0A01, 16'h0200, 1'b0, 1'b0);
        apply_stimulus("pre_rst1", 1'b1, 16'h0A02, 16'h0201, 1'b0, 1'b0);
        apply_stimulus("pre_rst2", 1'b1, 16'h0A03, 16'h0202, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        model_q.delete();
        #1;
        check_output("async_rst");
        #1;
        rst = 1'b0;
        apply_stimulus("post_rst", 1'b1, 16'hF800, 16'h0300, 1'b0, 1'b0);
        check("post_rst.opco_const", 32'(opco_out), 32'hF);
        check("post_rst.jmp_const", 32'(jmp_off_out), 32'h2);
        apply_stimulus("final_pop", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
